// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int unsigned XLEN             = 32;
   localparam logic [XLEN-1:0] NOP_INSTRUCTION  = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int unsigned PC_INCREMENT     = 4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pipeline control, program memory port and IF/ID outputs.
interface fetch_unit_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                  stall;
   logic                  flush;
   logic                  branch_taken;
   logic [DATA_WIDTH-1:0] branch_target;
   logic                  jump;
   logic [DATA_WIDTH-1:0] jump_target;
   logic [DATA_WIDTH-1:0] instruction;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] if_id_instruction;
   logic [DATA_WIDTH-1:0] if_id_pcplus4;
   logic                  if_id_valid;
   logic                  align_err;

   // Pipeline control and program memory side
   modport master (
      output stall, flush, branch_taken, branch_target, jump, jump_target, instruction,
      input  pc, if_id_instruction, if_id_pcplus4, if_id_valid, align_err
   );

   // Fetch unit side
   modport slave (
      input  stall, flush, branch_taken, branch_target, jump, jump_target, instruction,
      output pc, if_id_instruction, if_id_pcplus4, if_id_valid, align_err
   );

endinterface : fetch_unit_if

// File: rtl/register_en_clr.sv
// Register with async active-low reset, load enable and synchronous clear-to-value.
module register_en_clr #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
   parameter logic [WIDTH-1:0]     CLR_VALUE   = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Clear wins over enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RESET_VALUE;
      end else if (clr) begin
         q <= CLR_VALUE;
      end else if (en) begin
         q <= d;
      end
   end

endmodule : register_en_clr

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.slave  bus
);

   localparam int unsigned IF_ID_WIDTH = 2 * DATA_WIDTH + 1;
   localparam logic [IF_ID_WIDTH-1:0] IF_ID_BUBBLE =
      {DATA_WIDTH'(NOP_INSTRUCTION), {DATA_WIDTH{1'b0}}, 1'b0};

   logic [DATA_WIDTH-1:0]  pc_q;
   logic [DATA_WIDTH-1:0]  pc_plus4_c;
   logic [DATA_WIDTH-1:0]  target_c;
   logic [DATA_WIDTH-1:0]  next_pc_c;
   logic                   redirect_c;
   logic                   pc_en_c;
   logic                   misaligned_c;
   logic                   if_id_en_c;
   logic                   if_id_clr_c;
   logic [IF_ID_WIDTH-1:0] if_id_d_c;
   logic [IF_ID_WIDTH-1:0] if_id_q;
   logic                   align_err_q;

   // Wraps modulo 2^DATA_WIDTH
   assign pc_plus4_c = pc_q + DATA_WIDTH'(PC_INCREMENT);

   // Next-PC and IF/ID control: jump beats branch, any redirect beats stall
   always_comb begin
      redirect_c   = 1'b0;
      target_c     = bus.jump_target;
      next_pc_c    = pc_plus4_c;
      pc_en_c      = 1'b0;
      misaligned_c = 1'b0;
      if_id_en_c   = 1'b0;
      if_id_clr_c  = 1'b0;
      if_id_d_c    = {bus.instruction, pc_plus4_c, 1'b1};

      if (bus.jump) begin
         redirect_c = 1'b1;
         target_c   = bus.jump_target;
      end else if (bus.branch_taken) begin
         redirect_c = 1'b1;
         target_c   = bus.branch_target;
      end

      if (redirect_c) begin
         next_pc_c    = {target_c[DATA_WIDTH-1:2], 2'b00};
         misaligned_c = |target_c[1:0];
      end

      pc_en_c     = redirect_c | ~bus.stall;
      if_id_clr_c = redirect_c | bus.flush;
      if_id_en_c  = ~bus.stall;
   end

   register_en_clr #(
      .WIDTH       (DATA_WIDTH),
      .RESET_VALUE (RESET_PC),
      .CLR_VALUE   (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (reset),
      .en    (pc_en_c),
      .clr   (1'b0),
      .d     (next_pc_c),
      .q     (pc_q)
   );

   register_en_clr #(
      .WIDTH       (IF_ID_WIDTH),
      .RESET_VALUE (IF_ID_BUBBLE),
      .CLR_VALUE   (IF_ID_BUBBLE)
   ) u_if_id_reg (
      .clk   (clk),
      .rst_n (reset),
      .en    (if_id_en_c),
      .clr   (if_id_clr_c),
      .d     (if_id_d_c),
      .q     (if_id_q)
   );

   // Sticky until reset
   register_en_clr #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0),
      .CLR_VALUE   (1'b0)
   ) u_align_err_reg (
      .clk   (clk),
      .rst_n (reset),
      .en    (misaligned_c),
      .clr   (1'b0),
      .d     (1'b1),
      .q     (align_err_q)
   );

   assign bus.pc                = pc_q;
   assign bus.if_id_instruction = if_id_q[IF_ID_WIDTH-1 -: DATA_WIDTH];
   assign bus.if_id_pcplus4     = if_id_q[DATA_WIDTH -: DATA_WIDTH];
   assign bus.if_id_valid       = if_id_q[0];
   assign bus.align_err         = align_err_q;

endmodule : fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of PC, instruction and target buses.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (word address 0 of program memory).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Stall  input  1  hold PC and IF/ID register.
REQ-006 Flush  input  1  replace IF/ID contents with a bubble.
REQ-007 BranchTaken  input  1  redirect PC to BranchTarget.
REQ-008 BranchTarget  input  DATA_WIDTH  branch destination byte address.
REQ-009 Jump  input  1  redirect PC to JumpTarget.
REQ-010 JumpTarget  input  DATA_WIDTH  jump destination byte address.
REQ-011 Instruction  input  DATA_WIDTH  combinational read data from program memory for address PC.
REQ-012 PC  output  DATA_WIDTH  current fetch byte address; drives program memory Address.
REQ-013 IF_ID_Instruction  output  DATA_WIDTH  registered instruction for decode.
REQ-014 IF_ID_PCPlus4  output  DATA_WIDTH  registered PC+4 of that instruction.
REQ-015 IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-016 AlignErr  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-017 PC SHALL be a register; the fetch unit SHALL NOT register Instruction before it reaches the IF/ID register (program memory is combinational).
REQ-018 Next-PC priority SHALL be: Jump > BranchTaken > Stall (hold) > PC+4.
REQ-019 A redirect (Jump or BranchTaken) SHALL override Stall in the same cycle.
REQ-020 Redirect target bits [1:0] SHALL be forced to 2'b00 before loading PC.
REQ-021 PC+4 SHALL be computed modulo 2^DATA_WIDTH: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
REQ-022 IF/ID update priority SHALL be: redirect or Flush -> bubble; else Stall -> hold; else load {Instruction, PC+4, Valid=1}.
REQ-023 Bubble SHALL be IF_ID_Instruction=32'h0000_0000 (MIPS NOP), IF_ID_PCPlus4=0, IF_ID_Valid=0.
REQ-024 Flush without redirect SHALL NOT alter PC sequencing: PC advances by 4, or holds if Stall=1.
REQ-025 Latency: the instruction addressed by PC at edge N SHALL appear on IF_ID outputs after edge N+1; IF/ID captures on the same edge that advances PC.
REQ-026 AlignErr SHALL set on any edge where a selected redirect target has bits [1:0] != 0 and SHALL clear only on reset.
REQ-027 An unselected target (e.g. BranchTarget while Jump=1) SHALL NOT affect AlignErr.

Reset
REQ-028 On reset=0, asynchronously: PC=RESET_PC, IF/ID = bubble, AlignErr=0.
REQ-029 Reset asserted mid-operation SHALL discard any pending redirect, stall or flush.
REQ-030 First valid IF/ID capture SHALL occur on the first rising edge after reset deasserts with Stall=0.

Structure
REQ-031 Shared package SHALL hold: NOP_INSTRUCTION (32'h0000_0000), default RESET_PC, PC_INCREMENT (4).
REQ-032 One sub-module: register_en_clr (parameterised width, async active-low reset, enable, synchronous clear-to-value), instantiated for PC and IF/ID fields.
REQ-033 Next-PC and IF/ID select logic SHALL be combinational in fetch_unit itself; no other hierarchy.

Verification
REQ-034 Reset release, no control inputs, memory words 0..3 = A,B,C,D -> PC 0,4,8,12; IF_ID_Instruction A,B,C on successive edges, PCPlus4 4,8,12, Valid=1.
REQ-035 Stall=1 for 2 cycles at PC=8 -> PC stays 8 and IF/ID holds B/8 for both cycles; sequencing resumes at 12 afterwards.
REQ-036 BranchTaken=1, BranchTarget=0x40 with Stall=1 -> next PC=0x40, IF/ID bubble (Valid=0, instr 0), AlignErr=0.
REQ-037 Jump=1, JumpTarget=0x102 together with BranchTaken=1, BranchTarget=0x200 -> PC=0x100, AlignErr=1 and stays 1 until reset.
REQ-038 PC=32'hFFFF_FFFC, no control -> next PC=0, IF_ID_PCPlus4=0, Valid=1.
REQ-039 Flush=1 alone at PC=4 -> PC=8, IF/ID bubble; reset pulse mid-stall -> PC=RESET_PC, Valid=0, AlignErr=0 immediately, without a clock edge.
